// File: rtl/console_uart_tx.sv
// Console output peripheral: console-address byte stores are queued in a FIFO
// and serialized as 8N1 on uart_tx; a status word can be polled by software.
module console_uart_tx #(
    parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
    parameter logic [31:0] STATUS_ADDRESS  = 32'h1000_0004,
    parameter int          CLKS_PER_BIT    = 16,
    parameter int          FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic [31:0] data_memory_interface_read_data,
    output logic        data_memory_interface_read_valid,
    output logic        uart_tx,
    output logic        busy
);

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic          overflow;

    logic          push_req;
    logic          read_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    head;
    logic [31:0]   status;
    logic          unused_bits;

    assign push_req = data_memory_interface_enable
                   && (data_memory_interface_state == WRITE)
                   && (data_memory_interface_address == CONSOLE_ADDRESS)
                   && data_memory_interface_frame_mask[3];

    assign read_req = data_memory_interface_enable
                   && (data_memory_interface_state == READ)
                   && (data_memory_interface_address == STATUS_ADDRESS);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW])
                     && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count      = wr_ptr - rd_ptr;
    assign head       = mem[rd_ptr[AW-1:0]];

    // A pop frees a slot on the same edge, so a push into a full FIFO
    // is still accepted when the transmitter takes a byte.
    assign pop = !fifo_empty
              && ((state == IDLE) || ((state == STOP) && (baud == BAUD_MAX)));
    assign push_ok = push_req && (!fifo_full || pop);

    assign busy = !fifo_empty || (state != IDLE);

    assign status = {16'h0, 8'(count), 4'h0, overflow,
                     fifo_full, fifo_empty, state != IDLE};

    assign unused_bits = ^{data_memory_interface_write_data[31:8],
                           data_memory_interface_frame_mask[2:0]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_memory_interface_write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            data_memory_interface_read_data  <= '0;
            data_memory_interface_read_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A drop on the same edge as a status read wins over the clear.
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (read_req) begin
                overflow <= 1'b0;
            end
            data_memory_interface_read_valid <= read_req;
            data_memory_interface_read_data  <= read_req ? status : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            uart_tx <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= head;
                        baud    <= '0;
                        state   <= START;
                        uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_MAX) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_MAX) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_MAX) begin
                        baud <= '0;
                        if (pop) begin
                            shift   <= head;
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Scoreboard bench for console_uart_tx: queue-based reference model,
// UART line decoder and status-read monitor.
module tb_console_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] CON = 32'h1000_0000;
    localparam logic [31:0] STA = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        uart_tx;
    logic        busy;

    console_uart_tx #(
        .CONSOLE_ADDRESS(CON),
        .STATUS_ADDRESS (STA),
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk                              (clk),
        .reset                            (reset),
        .data_memory_interface_enable     (en),
        .data_memory_interface_state      (st),
        .data_memory_interface_address    (addr),
        .data_memory_interface_frame_mask (mask),
        .data_memory_interface_write_data (wdata),
        .data_memory_interface_read_data  (rdata),
        .data_memory_interface_read_valid (rvalid),
        .uart_tx                          (uart_tx),
        .busy                             (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: byte queue plus the start edge of the frame in flight.
    logic [7:0]  mq[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_status[$];
    bit          m_active;
    bit          m_ovf;
    int          m_start;
    logic [7:0]  m_byte;
    int          t;
    int          j;
    int          b;
    bit          wr_req;
    bit          rd_req;
    bit          end_now;
    bit          do_pop;
    bit          accept;
    logic        exp_line = 1'b1;
    logic        exp_busy = 1'b0;
    logic        exp_rv   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            exp_bytes.delete();
            exp_status.delete();
            m_active = 0;
            m_ovf    = 0;
            t        = 0;
            exp_line = 1'b1;
            exp_busy = 1'b0;
            exp_rv   = 1'b0;
        end else begin
            t++;
            wr_req = en && st && addr == CON && mask[3];
            rd_req = en && !st && addr == STA;
            if (rd_req) begin
                exp_status.push_back({16'h0, 8'(mq.size()), 4'h0, m_ovf,
                                      mq.size() == DEPTH, mq.size() == 0,
                                      m_active});
            end
            end_now = m_active && (t - m_start == 10 * CPB);
            do_pop  = mq.size() != 0 && (!m_active || end_now);
            accept  = wr_req && (mq.size() < DEPTH || do_pop);
            if (do_pop) begin
                m_byte = mq.pop_front();
                exp_bytes.push_back(m_byte);
                m_active = 1;
                m_start  = t;
            end else if (end_now) begin
                m_active = 0;
            end
            if (accept) mq.push_back(wdata[7:0]);
            if (wr_req && !accept) m_ovf = 1;
            else if (rd_req) m_ovf = 0;
            exp_rv   = rd_req;
            exp_busy = mq.size() != 0 || m_active;
            if (m_active) begin
                j = t - m_start;
                b = j / CPB;
                exp_line = (b == 0) ? 1'b0 : (b <= 8) ? m_byte[b-1] : 1'b1;
            end else begin
                exp_line = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("uart_tx_line", uart_tx, exp_line);
            chk("busy", busy, exp_busy);
            chk("read_valid", rvalid, exp_rv);
            if (!rvalid) chk("read_data_idle", rdata, 32'h0);
        end
    end

    always @(negedge clk) begin
        if (reset && rvalid) begin
            if (exp_status.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL status: got %h, no read outstanding", rdata);
            end else begin
                chk("status", rdata, exp_status.pop_front());
            end
        end
    end

    bit         dec_active = 0;
    int         dec_k;
    logic       dec_start;
    logic [7:0] dec_byte;

    always @(negedge clk) begin
        if (!reset) begin
            dec_active = 0;
        end else if (!dec_active) begin
            if (uart_tx == 1'b0) begin
                dec_active = 1;
                dec_k = 0;
            end
        end else begin
            dec_k++;
            if (dec_k == CPB / 2) dec_start = uart_tx;
            for (int i = 0; i < 8; i++) begin
                if (dec_k == CPB / 2 + (i + 1) * CPB) dec_byte[i] = uart_tx;
            end
            if (dec_k == CPB / 2 + 9 * CPB) begin
                dec_active = 0;
                if (exp_bytes.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL uart_frame: got byte %h, none expected", dec_byte);
                end else begin
                    chk("uart_frame", {dec_start, uart_tx, dec_byte},
                        {1'b0, 1'b1, exp_bytes.pop_front()});
                end
            end
        end
    end

    task automatic drive(bit e, bit s, logic [31:0] a, logic [3:0] m,
                         logic [31:0] d);
        en = e;
        st = s;
        addr = a;
        mask = m;
        wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (busy && k < budget) begin
            idle(1);
            k++;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        logic [3:0] m;
        reset = 1'b0;
        en = 0;
        st = 0;
        addr = 0;
        mask = 0;
        wdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_uart_tx", uart_tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_read_valid", rvalid, 0);
        chk("reset_read_data", rdata, 0);
        reset = 1'b1;
        idle(2);

        drive(1, 0, STA, 4'h0, 32'h0);
        chk("empty_status", rdata, 32'h0000_0002);
        chk("empty_status_valid", rvalid, 1);
        idle(1);
        chk("empty_status_valid_drop", rvalid, 0);
        chk("empty_status_data_drop", rdata, 0);

        drive(1, 1, CON, 4'b1000, 32'h41);
        n = 0;
        while (busy && n < 200) begin
            n++;
            idle(1);
        end
        chk("single_busy_cycles", n, 41);
        idle(3);

        for (int i = 0; i < 10; i++) drive(1, 1, CON, 4'b1000, 32'h30 + i);
        drive(1, 0, STA, 4'h0, 32'h0);
        chk("overflow_status", rdata, 32'h0000_080D);
        drive(1, 0, STA, 4'h0, 32'h0);
        chk("overflow_cleared", rdata, 32'h0000_0805);
        wait_idle(20 * 10 * CPB);

        drive(1, 1, CON, 4'b0001, 32'h55);
        drive(1, 1, 32'h1000_0008, 4'b1000, 32'h55);
        drive(1, 0, STA, 4'h0, 32'h0);
        chk("filter_status", rdata, 32'h0000_0002);
        chk("filter_busy", busy, 0);
        idle(2 * 10 * CPB);

        for (int i = 0; i < 3; i++) drive(1, 1, CON, 4'b1000, 32'h61 + i);
        idle(16);
        chk("pre_reset_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_uart_tx", uart_tx, 1);
        chk("async_reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(1);
        drive(1, 0, STA, 4'h0, 32'h0);
        chk("post_reset_status", rdata, 32'h0000_0002);
        idle(2 * 10 * CPB);

        for (int i = 0; i < 9; i++) drive(1, 1, CON, 4'b1000, 32'h70 + i);
        idle(10 * CPB - 8);
        drive(1, 1, CON, 4'b1000, 32'h7F);
        drive(1, 0, STA, 4'h0, 32'h0);
        chk("full_pushpop_status", rdata, 32'h0000_0805);
        wait_idle(20 * 10 * CPB);

        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                m = 4'($urandom_range(0, 15));
                if (r <= 2) m[3] = 1'b1;
                drive(1, 1, CON, m, $urandom);
            end else if (r == 5) begin
                drive(1, 1, CON + 4 * $urandom_range(1, 3), 4'b1000, $urandom);
            end else if (r == 6) begin
                drive(1, 0, STA, 4'($urandom_range(0, 15)), $urandom);
            end else if (r == 7) begin
                drive(1, 0, CON, 4'b1000, $urandom);
            end else begin
                idle($urandom_range(1, 20));
            end
        end
        wait_idle(40 * 10 * CPB);
        idle(5);
        chk("bytes_outstanding", exp_bytes.size(), 0);
        chk("reads_outstanding", exp_status.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
